b01_serial_tx: RTL and testbench
================================

Name: b01_serial_tx

Overview:
- Transmit end of the b01 serial two-operand link.
- Accepts parallel operand pairs (A, B) on a valid/ready handshake and drives them LSB-first on LINE1/LINE2 in fixed, free-running W-bit frames, matching the b01 frame cadence.
- Inserts all-zero idle frames when no operand pair is available, so frame alignment never slips.
- Publishes the expected sum and carry-out of each data frame for the verification scoreboard.

Parameters:
- W, 4, frame length in bits (operand width); legal range W >= 2.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair available
- in_ready  output  1  block accepts a pair this cycle
- in_a  input  W  operand A, driven on LINE1
- in_b  input  W  operand B, driven on LINE2
- LINE1  output  1  serial bit of A, LSB first
- LINE2  output  1  serial bit of B, LSB first
- frame_start  output  1  high while bit 0 of any frame (data or idle) is on LINE1/LINE2
- frame_data  output  1  high for all W bit-cycles of a data frame; low during idle frames
- exp_valid  output  1  one-cycle pulse coincident with frame_start of a data frame
- exp_sum  output  W  (A+B) mod 2^W for the frame being sent; held until the next data frame
- exp_cout  output  1  carry out of A+B; held with exp_sum

Behaviour:
- State: bit counter cnt[$clog2(W)-1:0], shift registers sa and sb (W bits each), frame_data flag, expected-result registers. All outputs are registered except in_ready.
- Reset (synchronous, takes priority over all other activity):
  - cnt=W-1; sa, sb, exp_sum = 0; exp_cout, exp_valid, frame_start, frame_data = 0.
  - LINE1 = LINE2 = 0 in the cycle after reset is sampled.
- Counter: cnt advances by 1 every clock and wraps from W-1 to 0. It never stalls.
- Handshake:
  - in_ready = (cnt==W-1) & ~reset. The first cycle after reset release has in_ready=1.
  - Transfer occurs when in_valid & in_ready.
  - The producer must keep in_valid high and in_a/in_b stable until the transfer. The bench flags a violation.
- Load edge (cnt==W-1):
  - With a transfer:
    - sa<=in_a, sb<=in_b, frame_data<=1.
    - exp_sum<=in_a+in_b (low W bits); exp_cout<=carry out.
    - exp_valid<=1 for exactly one cycle.
  - Without a transfer:
    - sa, sb <= 0 (idle frame); frame_data<=0.
    - exp_sum and exp_cout hold; exp_valid<=0.
  - In both cases frame_start<=1.
- Other edges: sa<=sa>>1 and sb<=sb>>1, zero-filling from the MSB; frame_start<=0; exp_valid<=0.
- LINE outputs: LINE1=sa[0] and LINE2=sb[0], so bit k of a frame is on the lines during cnt==k.
- Latency: the accepted pair's bit 0 appears on the lines one cycle after the transfer edge. The last bit appears W cycles after the transfer edge.
- Back-to-back: with in_valid held high, data frames are contiguous with no idle gap; throughput is one pair per W cycles.
- Reset mid-frame: the frame is abandoned and not retransmitted. The lines go to 0 and the next frame_start comes one cycle after release.
- Consumer alignment: a b01 receiver reset in the same cycle starts its frame on the first frame_start.

Decomposition:
- Package b01_pkg:
  - FRAME_W = 4.
  - typedef word_t = logic [FRAME_W-1:0].
  - typedef bitcnt_t sized $clog2(FRAME_W).
  - Constant IDLE_WORD = '0.
- One natural sub-module, b01_lane_shifter: a W-bit load/shift-right register with serial LSB output, instantiated once per lane (LINE1, LINE2).
- Counter, handshake and expected-result logic stay in b01_serial_tx.

Test Plan:
1. Release reset, hold in_valid=0 for 16 cycles -> LINE1=LINE2=0 throughout; frame_start high in cycles 1, 5, 9, 13 after release; frame_data=0; exp_valid never pulses.
2. A=4'b1011, B=4'b0110 presented at release -> accepted in cycle 0; LINE1 sequence 1,1,0,1; LINE2 sequence 0,1,1,0; exp_sum=4'b0001 and exp_cout=1 with exp_valid at bit 0.
3. Continuous in_valid with pairs (F,1), then (3,3), then (0,0) -> three contiguous data frames; in_ready high once per 4 cycles; exp results (0,1), (6,0), (0,0); no idle frame between them.
4. Raise in_valid with A=5, B=A at cnt=1 -> in_ready stays low for 2 cycles; transfer at cnt=3; current frame stays idle zeros; next frame carries 1,0,1,0 on both lines; exp_sum=4'hA, exp_cout=0.
5. Assert reset during bit 2 of the data frame A=F, B=F -> next cycle LINE1=LINE2=0 and frame_data=0; in_ready=1 in the first cycle after release; the pair is not resent; exp_cout stays 0 from reset.
6. Scoreboard run: 200 random pairs with random in_valid gaps, b01 connected downstream -> every data frame's W LINE bits reconstruct A and B exactly; exp_sum and exp_cout match A+B; frame_start period is exactly W cycles.

Source files
------------

// File: rtl/b01_pkg.sv
// rtl/b01_pkg.sv - shared types and constants for the b01 serial link
package b01_pkg;

  localparam int FRAME_W = 4;

  typedef logic [FRAME_W-1:0]         word_t;
  typedef logic [$clog2(FRAME_W)-1:0] bitcnt_t;

  localparam word_t IDLE_WORD = '0;

endpackage

// File: rtl/b01_serial_tx_if.sv
// rtl/b01_serial_tx_if.sv - operand-pair valid/ready handshake into the serial transmitter
interface b01_serial_tx_if
  import b01_pkg::*;
#(
  parameter int W = FRAME_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);

endinterface

// File: rtl/b01_lane_shifter.sv
// rtl/b01_lane_shifter.sv - W-bit load / shift-right register with LSB serial output
module b01_lane_shifter
  import b01_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         serial
);

  logic [W-1:0] sr;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else begin
      sr <= sr >> 1;
    end
  end

  assign serial = sr[0];

endmodule

// File: rtl/b01_serial_tx.sv
// rtl/b01_serial_tx.sv - free-running framed serial transmitter for A/B operand pairs
module b01_serial_tx
  import b01_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic           clock,
  input  logic           reset,
  b01_serial_tx_if.slave bus,
  output logic           LINE1,
  output logic           LINE2,
  output logic           frame_start,
  output logic           frame_data,
  output logic           exp_valid,
  output logic [W-1:0]   exp_sum,
  output logic           exp_cout
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] cnt;
  logic          load;
  logic          xfer;
  logic [W:0]    sum_full;
  logic [W-1:0]  word_a;
  logic [W-1:0]  word_b;

  // Frames never stall: the load slot recurs every W cycles whether or not data is waiting.
  assign load         = (cnt == CW'(W - 1));
  assign bus.in_ready = load & ~reset;
  assign xfer         = bus.in_valid & bus.in_ready;
  assign sum_full     = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign word_a       = xfer ? bus.in_a : W'(IDLE_WORD);
  assign word_b       = xfer ? bus.in_b : W'(IDLE_WORD);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= CW'(W - 1);
      frame_start <= 1'b0;
      frame_data  <= 1'b0;
      exp_valid   <= 1'b0;
      exp_sum     <= '0;
      exp_cout    <= 1'b0;
    end else begin
      cnt         <= load ? '0 : cnt + 1'b1;
      frame_start <= load;
      exp_valid   <= xfer;
      if (load) begin
        frame_data <= xfer;
      end
      if (xfer) begin
        exp_sum  <= sum_full[W-1:0];
        exp_cout <= sum_full[W];
      end
    end
  end

  b01_lane_shifter #(.W(W)) u_lane1 (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .din    (word_a),
    .serial (LINE1)
  );

  b01_lane_shifter #(.W(W)) u_lane2 (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .din    (word_b),
    .serial (LINE2)
  );

endmodule

// File: tb/tb_b01_serial_tx.sv
// tb/tb_b01_serial_tx.sv - scoreboard bench for b01_serial_tx
module tb_b01_serial_tx;
  import b01_pkg::*;

  localparam int W = FRAME_W;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         LINE1, LINE2, frame_start, frame_data, exp_valid, exp_cout;
  logic [W-1:0] exp_sum;

  b01_serial_tx_if #(.W(W)) bus ();

  b01_serial_tx #(.W(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .LINE1       (LINE1),
    .LINE2       (LINE2),
    .frame_start (frame_start),
    .frame_data  (frame_data),
    .exp_valid   (exp_valid),
    .exp_sum     (exp_sum),
    .exp_cout    (exp_cout)
  );

  always #5 clock = ~clock;

  int    errors = 0;
  int    checks = 0;
  pair_t sb[$];
  int    pos;
  logic  rst_q;
  int    cyc = 0;
  int    last_xfer_cyc;
  int    pushes = 0;
  int    data_frames = 0;
  int    fs_count = 0;
  int    ev_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame position seen from outside: reset parks at the last slot, then one step per clock.
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
    pos   <= reset ? W - 1 : (pos + 1) % W;
  end

  // Monitor: consumes the scoreboard one frame at a time.
  pair_t        cur;
  logic         cur_data = 1'b0;
  logic [W-1:0] rx_a, rx_b;
  int           model_sum = 0;
  int           model_cout = 0;

  always @(negedge clock) begin
    int s;
    if (frame_start === 1'b1) fs_count++;
    if (exp_valid === 1'b1) ev_count++;
    if (rst_q) begin
      check("rst_line1", LINE1, 0);
      check("rst_line2", LINE2, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_frame_data", frame_data, 0);
      check("rst_exp_valid", exp_valid, 0);
      check("rst_exp_sum", exp_sum, 0);
      check("rst_exp_cout", exp_cout, 0);
      cur_data   = 1'b0;
      model_sum  = 0;
      model_cout = 0;
    end else begin
      if (pos == 0) begin
        cur_data = (sb.size() > 0);
        if (cur_data) begin
          cur        = sb.pop_front();
          s          = int'(cur.a) + int'(cur.b);
          model_sum  = s % (1 << W);
          model_cout = (s >= (1 << W)) ? 1 : 0;
          data_frames++;
        end
        rx_a = '0;
        rx_b = '0;
      end
      check("frame_start", frame_start, (pos == 0) ? 1 : 0);
      check("exp_valid", exp_valid, (pos == 0 && cur_data) ? 1 : 0);
      check("frame_data", frame_data, cur_data);
      rx_a[pos] = LINE1;
      rx_b[pos] = LINE2;
      if (pos == W - 1) begin
        check("frame_a", rx_a, cur_data ? cur.a : 0);
        check("frame_b", rx_b, cur_data ? cur.b : 0);
      end
      check("exp_sum", exp_sum, model_sum);
      check("exp_cout", exp_cout, model_cout);
    end
    check("in_ready", bus.in_ready, (pos == W - 1 && !reset) ? 1 : 0);
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4 * W && !done; i++) begin
      @(negedge clock);
      if (bus.in_ready === 1'b1) begin
        sb.push_back('{a: a, b: b});
        pushes++;
        last_xfer_cyc = cyc;
        done = 1;
      end
    end
    if (!done) check("send_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (pos != p && n < 4 * W);
    if (pos != p) check("wait_pos_timeout", pos, p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, fc0, ev0, df0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    cycles(3);

    // Idle link after release
    reset = 1'b0;
    fs_count = 0;
    ev0 = ev_count;
    cycles(16);
    check("t1_frame_starts", fs_count, 4);
    check("t1_exp_valid_pulses", ev_count - ev0, 0);
    check("t1_data_frames", data_frames, 0);

    // Pair presented at release
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    t0 = cyc;
    send(4'b1011, 4'b0110);
    bus.in_valid = 1'b0;
    check("t2_accept_cycle", last_xfer_cyc - t0, 0);
    cycles(W + 1);
    check("t2_exp_sum", exp_sum, 4'b0001);
    check("t2_exp_cout", exp_cout, 1);

    // Back-to-back frames
    send(4'hF, 4'h1);
    t0 = last_xfer_cyc;
    df0 = data_frames;
    send(4'h3, 4'h3);
    send(4'h0, 4'h0);
    bus.in_valid = 1'b0;
    check("t3_contiguous", last_xfer_cyc - t0, 2 * W);
    cycles(2 * W);
    check("t3_frames", data_frames - df0, 3);
    check("t3_exp_sum", exp_sum, 0);

    // Valid raised mid-frame waits for the load slot
    wait_pos(1);
    t0 = cyc;
    send(4'h5, 4'h5);
    bus.in_valid = 1'b0;
    check("t4_wait", last_xfer_cyc - t0, 2);
    cycles(W + 1);
    check("t4_exp_sum", exp_sum, 4'hA);
    check("t4_exp_cout", exp_cout, 0);

    // Reset during bit 2 abandons the frame
    send(4'hF, 4'hF);
    bus.in_valid = 1'b0;
    wait_pos(2);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    @(negedge clock);
    check("t5_ready_after_release", bus.in_ready, 1);
    check("t5_exp_cout", exp_cout, 0);
    fc0 = data_frames;
    cycles(3 * W);
    check("t5_no_resend", data_frames, fc0);

    // Random traffic with gaps
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 2 * W);
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        cycles(gap);
      end
      send(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
    end
    bus.in_valid = 1'b0;
    cycles(3 * W);
    check("end_queue_empty", sb.size(), 0);
    check("end_frames", data_frames, pushes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
